// File: rtl/ks_pkg.sv
// Shared Karplus-Strong types: data width, sequencer state encoding and pattern step entry.
package ks_pkg;

  localparam int unsigned KS_DATA_WIDTH = 8;
  localparam int unsigned SEQ_TICK_W    = 16;
  localparam int unsigned SEQ_PLUCK_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLUCK   = 2'd1,
    SUSTAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                     rest;
    logic [KS_DATA_WIDTH-1:0] period;
  } step_entry_t;

  // Zero-length controls behave as one tick.
  function automatic logic [SEQ_TICK_W-1:0] min1_tick(input logic [SEQ_TICK_W-1:0] v);
    return (v == '0) ? SEQ_TICK_W'(1) : v;
  endfunction

  function automatic logic [SEQ_PLUCK_W-1:0] min1_pluck(input logic [SEQ_PLUCK_W-1:0] v);
    return (v == '0) ? SEQ_PLUCK_W'(1) : v;
  endfunction

endpackage

// File: rtl/ks_note_sequencer_if.sv
// Control, pattern-write and output bundle between the register map and the note sequencer.
interface ks_note_sequencer_if import ks_pkg::*; #(
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned DATA_WIDTH = KS_DATA_WIDTH,
  parameter int unsigned STEP_AW    = $clog2(NUM_STEPS)
);

  logic                  sample_tick_i;
  logic                  start_i;
  logic                  stop_i;
  logic                  loop_en_i;
  logic [STEP_AW:0]      length_i;
  logic [15:0]           step_len_i;
  logic [7:0]            pluck_len_i;
  logic                  wr_en_i;
  logic [STEP_AW-1:0]    wr_addr_i;
  logic [DATA_WIDTH:0]   wr_data_i;

  logic [DATA_WIDTH-1:0] period_o;
  logic                  pluck_o;
  logic [STEP_AW-1:0]    step_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output sample_tick_i, start_i, stop_i, loop_en_i, length_i, step_len_i, pluck_len_i,
           wr_en_i, wr_addr_i, wr_data_i,
    input  period_o, pluck_o, step_o, busy_o, done_o
  );

  modport slave (
    input  sample_tick_i, start_i, stop_i, loop_en_i, length_i, step_len_i, pluck_len_i,
           wr_en_i, wr_addr_i, wr_data_i,
    output period_o, pluck_o, step_o, busy_o, done_o
  );

endinterface

// File: rtl/ks_seq_pattern_ram.sv
// Flop-based note pattern store: synchronous write, combinational read, cleared by reset.
module ks_seq_pattern_ram import ks_pkg::*; #(
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned DATA_WIDTH = KS_DATA_WIDTH,
  parameter int unsigned STEP_AW    = $clog2(NUM_STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [STEP_AW-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH:0] wr_data_i,
  input  logic [STEP_AW-1:0]  rd_addr_i,
  output logic [DATA_WIDTH:0] rd_data_c
);

  logic [DATA_WIDTH:0] mem_q [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A same-cycle write to the read address is seen only from the next cycle.
  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer driving ks_string period/pluck from a programmable note pattern, timed in KS sample ticks.
module ks_note_sequencer import ks_pkg::*; #(
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned DATA_WIDTH = KS_DATA_WIDTH,
  parameter int unsigned STEP_AW    = $clog2(NUM_STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  ks_note_sequencer_if.slave  bus
);

  localparam int unsigned LEN_W   = STEP_AW + 1;
  localparam int unsigned TICK_W  = SEQ_TICK_W;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  seq_state_t            state_q;
  logic [TICK_W-1:0]     tick_cnt_q;
  logic [STEP_AW-1:0]    step_q;
  logic [DATA_WIDTH-1:0] period_q;
  logic                  rest_q;
  logic                  pluck_q;
  logic                  busy_q;
  logic                  done_q;

  logic [STEP_AW-1:0]    rd_addr_c;
  logic [ENTRY_W-1:0]    rd_data_c;
  logic                  ld_rest_c;
  logic [DATA_WIDTH-1:0] ld_period_c;
  logic [LEN_W-1:0]      last_c;
  logic [TICK_W:0]       tick_inc_c;
  logic                  step_end_c;
  logic                  pluck_end_c;
  logic                  at_last_c;

  ks_seq_pattern_ram #(
    .NUM_STEPS  (NUM_STEPS),
    .DATA_WIDTH (DATA_WIDTH),
    .STEP_AW    (STEP_AW)
  ) u_pattern_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en_i),
    .wr_addr_i (bus.wr_addr_i),
    .wr_data_i (bus.wr_data_i),
    .rd_addr_i (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  assign ld_rest_c   = rd_data_c[DATA_WIDTH];
  assign ld_period_c = rd_data_c[DATA_WIDTH-1:0];

  // Step/pluck end detection; >= keeps the pattern terminating when lengths shrink live.
  always_comb begin
    last_c      = LEN_W'(NUM_STEPS - 1);
    rd_addr_c   = '0;
    if ((bus.length_i != '0) && (bus.length_i <= LEN_W'(NUM_STEPS))) begin
      last_c = bus.length_i - LEN_W'(1);
    end
    tick_inc_c  = {1'b0, tick_cnt_q} + (TICK_W + 1)'(1);
    step_end_c  = tick_inc_c >= {1'b0, min1_tick(bus.step_len_i)};
    pluck_end_c = tick_inc_c >= (TICK_W + 1)'(min1_pluck(bus.pluck_len_i));
    at_last_c   = {1'b0, step_q} >= last_c;
    if ((state_q != IDLE) && !(at_last_c && bus.loop_en_i)) begin
      rd_addr_c = step_q + STEP_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      step_q     <= '0;
      period_q   <= '0;
      rest_q     <= 1'b0;
      pluck_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.stop_i) begin
      state_q <= IDLE;
      pluck_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q    <= PLUCK;
            tick_cnt_q <= '0;
            step_q     <= '0;
            period_q   <= ld_period_c;
            rest_q     <= ld_rest_c;
            pluck_q    <= ~ld_rest_c;
            busy_q     <= 1'b1;
          end
        end
        PLUCK, SUSTAIN: begin
          if (bus.sample_tick_i) begin
            if (step_end_c && at_last_c && !bus.loop_en_i) begin
              state_q <= IDLE;
              pluck_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (step_end_c) begin
              state_q    <= PLUCK;
              tick_cnt_q <= '0;
              step_q     <= rd_addr_c;
              period_q   <= ld_period_c;
              rest_q     <= ld_rest_c;
              pluck_q    <= ~ld_rest_c;
            end else if ((state_q == PLUCK) && pluck_end_c) begin
              state_q    <= SUSTAIN;
              tick_cnt_q <= tick_inc_c[TICK_W-1:0];
              pluck_q    <= 1'b0;
            end else begin
              tick_cnt_q <= tick_inc_c[TICK_W-1:0];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pluck_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period_o = period_q;
  assign bus.pluck_o  = pluck_q;
  assign bus.step_o   = step_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Scoreboard bench for ks_note_sequencer: expected per-tick outputs derived from the programmed pattern.
module tb_ks_note_sequencer;
  import ks_pkg::*;

  localparam int unsigned NS = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [7:0] period;
    logic       pluck;
    logic [2:0] step;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ks_note_sequencer_if #(.NUM_STEPS(NS), .DATA_WIDTH(DW)) bus ();

  ks_note_sequencer #(.NUM_STEPS(NS), .DATA_WIDTH(DW), .STEP_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t       sb_q[$];
  logic [8:0] mdl_mem [NS];
  obs_t       e_last;
  int         checks = 0;
  int         errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.period = bus.period_o;
    o.pluck  = bus.pluck_o;
    o.step   = bus.step_o;
    o.busy   = bus.busy_o;
    o.done   = bus.done_o;
    return o;
  endfunction

  // Expected outputs after k ticks of a pattern started from step 0.
  function automatic obs_t model_at(input int k, input int len, input int sl, input int pl, input bit loop);
    obs_t e;
    int total, kk, s, t, pw;
    total = len * sl;
    pw    = (pl < sl) ? pl : sl;
    if (!loop && k >= total) begin
      e.period = mdl_mem[len-1][7:0];
      e.pluck  = 1'b0;
      e.step   = 3'(len - 1);
      e.busy   = 1'b0;
      e.done   = (k == total);
    end else begin
      kk       = loop ? (k % total) : k;
      s        = kk / sl;
      t        = kk % sl;
      e.period = mdl_mem[s][7:0];
      e.pluck  = !mdl_mem[s][8] && (t < pw);
      e.step   = 3'(s);
      e.busy   = 1'b1;
      e.done   = 1'b0;
    end
    return e;
  endfunction

  task automatic clk_cycle(input bit tick);
    bus.sample_tick_i = tick;
    @(posedge clk);
    #1;
    bus.sample_tick_i = 1'b0;
  endtask

  task automatic sb_push(input obs_t e);
    sb_q.push_back(e);
    e_last = e;
  endtask

  task automatic sb_check(input string tag);
    obs_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=empty-scoreboard exp=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_eq(tag, 32'(observe()), 32'(e));
    end
  endtask

  task automatic pat_write(input int addr, input bit rest, input logic [7:0] period);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 3'(addr);
    bus.wr_data_i = {rest, period};
    clk_cycle(1'b0);
    bus.wr_en_i   = 1'b0;
    mdl_mem[addr] = {rest, period};
  endtask

  task automatic start_seq(input string tag, input int len, input int sl, input int pl, input bit loop);
    sb_push(model_at(0, len, sl, pl, loop));
    bus.start_i = 1'b1;
    clk_cycle(1'b0);
    bus.start_i = 1'b0;
    sb_check({tag, "_start"});
  endtask

  // Each tick is followed by an idle cycle that must not change anything but done.
  task automatic play(input string tag, input int k0, input int k1, input int len, input int sl,
                      input int pl, input bit loop);
    obs_t e;
    for (int k = k0; k <= k1; k++) begin
      e = model_at(k, len, sl, pl, loop);
      sb_push(e);
      clk_cycle(1'b1);
      sb_check($sformatf("%s_tick%0d", tag, k));
      e.done = 1'b0;
      sb_push(e);
      clk_cycle(1'b0);
      sb_check($sformatf("%s_gap%0d", tag, k));
    end
  endtask

  task automatic set_ctrl(input int len, input int sl, input int pl, input bit loop);
    bus.length_i    = 4'(len);
    bus.step_len_i  = 16'(sl);
    bus.pluck_len_i = 8'(pl);
    bus.loop_en_i   = loop;
  endtask

  initial begin
    obs_t e;
    bus.sample_tick_i = 1'b0;
    bus.start_i       = 1'b0;
    bus.stop_i        = 1'b0;
    bus.wr_en_i       = 1'b0;
    bus.wr_addr_i     = '0;
    bus.wr_data_i     = '0;
    set_ctrl(3, 4, 2, 1'b0);
    for (int i = 0; i < int'(NS); i++) mdl_mem[i] = '0;

    rst_n = 1'b0;
    clk_cycle(1'b0);
    sb_push(obs_t'(0));
    clk_cycle(1'b1);
    sb_check("reset");
    rst_n = 1'b1;

    // One-shot pattern
    pat_write(0, 1'b0, 8'h20);
    pat_write(1, 1'b0, 8'h40);
    pat_write(2, 1'b0, 8'h30);
    start_seq("oneshot", 3, 4, 2, 1'b0);
    play("oneshot", 1, 14, 3, 4, 2, 1'b0);

    // Looping pattern, then stop
    set_ctrl(3, 4, 2, 1'b1);
    start_seq("loop", 3, 4, 2, 1'b1);
    play("loop", 1, 17, 3, 4, 2, 1'b1);
    e = e_last;
    e.busy = 1'b0; e.pluck = 1'b0; e.done = 1'b0;
    sb_push(e);
    bus.stop_i = 1'b1;
    clk_cycle(1'b0);
    bus.stop_i = 1'b0;
    sb_check("loop_stop");

    // Stop at tick 2 of step 1, coincident with a tick
    set_ctrl(3, 4, 2, 1'b0);
    start_seq("stop", 3, 4, 2, 1'b0);
    play("stop", 1, 6, 3, 4, 2, 1'b0);
    e = e_last;
    e.busy = 1'b0; e.pluck = 1'b0; e.done = 1'b0;
    sb_push(e);
    bus.stop_i = 1'b1;
    clk_cycle(1'b1);
    bus.stop_i = 1'b0;
    sb_check("stop_idle");
    check_eq("stop_period", 32'(bus.period_o), 32'h40);
    for (int i = 0; i < 3; i++) begin
      sb_push(e);
      clk_cycle(1'b1);
      sb_check($sformatf("stop_hold%0d", i));
    end

    // Start and stop together in IDLE
    sb_push(e);
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    clk_cycle(1'b0);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    sb_check("start_stop");
    sb_push(e);
    clk_cycle(1'b1);
    sb_check("start_stop_hold");

    // Rest step
    pat_write(1, 1'b1, 8'h55);
    start_seq("rest", 3, 4, 2, 1'b0);
    play("rest", 1, 12, 3, 4, 2, 1'b0);

    // Pluck length clamped to step length
    pat_write(1, 1'b0, 8'h40);
    set_ctrl(3, 3, 10, 1'b0);
    start_seq("clamp", 3, 3, 10, 1'b0);
    play("clamp", 1, 9, 3, 3, 10, 1'b0);

    // Live write of step 2 while step 1 plays
    set_ctrl(3, 4, 2, 1'b0);
    start_seq("live", 3, 4, 2, 1'b0);
    play("live", 1, 5, 3, 4, 2, 1'b0);
    pat_write(2, 1'b0, 8'h77);
    play("live", 6, 13, 3, 4, 2, 1'b0);

    // Length shrinks 3 -> 1 during step 2
    start_seq("shrink", 3, 4, 2, 1'b0);
    play("shrink", 1, 9, 3, 4, 2, 1'b0);
    bus.length_i = 4'd1;
    play("shrink", 10, 13, 3, 4, 2, 1'b0);

    // Reset mid-step clears outputs and pattern
    set_ctrl(3, 4, 2, 1'b1);
    start_seq("rstmid", 3, 4, 2, 1'b1);
    play("rstmid", 1, 5, 3, 4, 2, 1'b1);
    sb_push(obs_t'(0));
    rst_n = 1'b0;
    clk_cycle(1'b1);
    rst_n = 1'b1;
    sb_check("reset_mid");
    for (int i = 0; i < int'(NS); i++) mdl_mem[i] = '0;
    set_ctrl(3, 1, 1, 1'b0);
    start_seq("ramzero", 3, 1, 1, 1'b0);
    play("ramzero", 1, 4, 3, 1, 1, 1'b0);

    // Zero length/step_len/pluck_len fall back to full depth and one tick
    pat_write(0, 1'b0, 8'h11);
    pat_write(1, 1'b1, 8'h22);
    pat_write(2, 1'b0, 8'h33);
    set_ctrl(0, 0, 0, 1'b0);
    start_seq("zero", 8, 1, 1, 1'b0);
    play("zero", 1, 9, 8, 1, 1, 1'b0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_note_sequencer.md
# ks_note_sequencer

Step sequencer that drives the Karplus-Strong string's `period` and `pluck` controls from a small programmable note pattern. It sits directly upstream of `ks_string`, alongside the SPI register map, and replaces the static `config_arr[7]` period and the `config_arr[4][0]` pluck bit when sequencing is enabled. All timing is counted in KS sample ticks: one-cycle enables at the `clk_r16` rate, generated in `clk` domain.

## Interface
Parameters:
- `NUM_STEPS`, 8: pattern depth (power of 2, 2..16).
- `DATA_WIDTH`, 8: period width, matches the KS data width.
- `STEP_AW`, $clog2(NUM_STEPS): step index width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_tick_i`  in  1  one-`clk` pulse per KS sample.
- `start_i`  in  1  level/pulse; starts the pattern from step 0 when idle.
- `stop_i`  in  1  aborts the pattern.
- `loop_en_i`  in  1  1 = wrap to step 0 after the last step; 0 = one-shot.
- `length_i`  in  STEP_AW+1  active steps; 0 or >NUM_STEPS means NUM_STEPS.
- `step_len_i`  in  16  ticks per step; 0 treated as 1.
- `pluck_len_i`  in  8  ticks `pluck_o` is held per step; 0 treated as 1.
- `wr_en_i`  in  1  pattern write strobe.
- `wr_addr_i`  in  STEP_AW  pattern write address.
- `wr_data_i`  in  DATA_WIDTH+1  {rest, period}.
- `period_o`  out  DATA_WIDTH  to `ks_string.period_i`.
- `pluck_o`  out  1  to `ks_string.pluck_i`.
- `step_o`  out  STEP_AW  current step index.
- `busy_o`  out  1  high outside IDLE.
- `done_o`  out  1  one-`clk` pulse on one-shot completion.

## Operation
- Pattern RAM: NUM_STEPS × (DATA_WIDTH+1) flops, written on `wr_en_i` at any time. A step entry is latched only when its step is entered. A write and a load of the same step in the same cycle latch the old value.
- FSM states: IDLE, PLUCK, SUSTAIN. `pluck_o = (state==PLUCK) & ~rest_q`.
- IDLE + `start_i` and no `stop_i`:
  - `step_o<=0`, `tick_cnt<=0`.
  - `period_o<=mem[0].period`, `rest_q<=mem[0].rest`.
  - Next state PLUCK.
- On each `sample_tick_i` in PLUCK/SUSTAIN, evaluated in this priority:
  - Step end: `tick_cnt+1 >= max(step_len_i,1)`. Then, if `step_o==last` (last = eff_length−1):
    - `loop_en_i=1`: load step 0.
    - `loop_en_i=0`: go to IDLE and pulse `done_o`.
  - Otherwise at step end: load step+1, `tick_cnt<=0`, state PLUCK.
  - Pluck end (PLUCK only, no step end): `tick_cnt+1 >= max(pluck_len_i,1)` → SUSTAIN, `tick_cnt++`.
  - Else `tick_cnt++`.
- A rest step runs its full duration with `pluck_o=0`. `period_o` still updates to the entry's period.
- `pluck_len_i >= step_len_i`: PLUCK spans the whole step. `pluck_o` stays high across consecutive non-rest steps.
- `stop_i` (any state, any cycle) → IDLE next edge, `pluck_o=0`, no `done_o`. `stop_i` wins over a simultaneous `start_i`.
- `start_i` while busy is ignored.
- Live changes to `step_len_i`, `pluck_len_i` or `length_i` apply at the next tick. The `>=` compares guarantee termination if a length shrinks below `tick_cnt` or `step_o`.
- `period_o` and `step_o` hold their last values in IDLE.

## Timing
- Reset values: state IDLE, RAM all 0, `period_o=0`, `pluck_o=0`, `step_o=0`, `busy_o=0`, `done_o=0`, `tick_cnt=0`.
- Start latency: `start_i` at edge N → `pluck_o`/`period_o`/`busy_o` valid after edge N. No tick alignment is needed to start.
- All state changes other than start, stop and reset happen only on `clk` edges where `sample_tick_i=1`.
- A non-rest step holds `pluck_o` for exactly min(pluck_len,step_len) ticks and lasts exactly step_len ticks.
- `done_o` is asserted in the same cycle `busy_o` falls.
- Reset mid-pattern returns to IDLE in one edge and clears the RAM.
- `tick_cnt` is 16-bit, and `step_len_i ≤ 65535` guarantees it cannot overflow.

## Structure
- Shared package `ks_pkg`: `KS_DATA_WIDTH`, the `seq_state_t` enum (IDLE/PLUCK/SUSTAIN), and the step-entry typedef `{logic rest; logic [KS_DATA_WIDTH-1:0] period;}`.
- One natural sub-module: `ks_seq_pattern_ram`, the write port plus combinational read.
- FSM and counters live in the top module.
- Top-level integration: a `config_arr[4]` bit selects sequencer outputs vs. the static `config_arr[7]` period and pluck bit. Pattern writes come through spare register-map addresses.

## Test plan
- One-shot: program {0x20,0x40,0x30}, length 3, step_len 4, pluck_len 2.
  - `period_o` = 0x20,0x40,0x30 for 4 ticks each.
  - `pluck_o` is high for the first 2 ticks of each step.
  - `done_o` pulses after tick 12, and `busy_o` falls in the same cycle.
- Loop: same pattern with `loop_en_i=1`. `step_o` goes 0,1,2,0,1 and `done_o` never asserts.
- Rest and clamp:
  - Step 1 = {rest=1,0x55}: `pluck_o` stays low for all 4 ticks of step 1, while `period_o=0x55`.
  - `pluck_len=10`, `step_len=3`: `pluck_o` stays continuously high across steps.
- Stop/start priority:
  - `stop_i` at tick 2 of step 1 → IDLE next edge, `pluck_o=0`, `period_o` holds 0x40, no `done_o`.
  - `start_i` and `stop_i` together in IDLE → stays IDLE.
- Live edits:
  - Write step 2 during step 1 → the new value plays.
  - Shrink `length_i` 3→1 during step 2 → the step ends and the sequencer goes to IDLE with `done_o` (one-shot).
- Reset mid-step: `rst_n=0` for 1 cycle → all outputs reach their reset values on that edge and the RAM reads 0.
